// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle sequencer: FSM state encoding, the
// decoder's instruction class encoding and the trap cause codes.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5,
    ST_TRAP    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_HALT    = 3'd5,
    CL_ILLEGAL = 3'd6
  } dec_class_t;

  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;

  // Classes that go through the MEM state.
  function automatic logic is_mem_class(input dec_class_t c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

  // Classes whose result is written back to rd (when dec_regwrite is set).
  function automatic logic writes_rd(input dec_class_t c);
    return (c == CL_ALU) || (c == CL_JUMP) || (c == CL_LOAD);
  endfunction

endpackage

// File: rtl/mc_timeout.sv
// Memory handshake watchdog. A down-counter that is reloaded while clear is
// high and counts down each cycle enable is high; expired flags the last
// allowed waiting cycle. LIMIT = 0 disables it (expired stays low).
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (reloads the counter)
//   clear    in   reload to LIMIT-1
//   enable   in   a request is waiting without an ack this cycle
//   expired  out  this is waiting cycle number LIMIT
module mc_timeout #(
  parameter int LIMIT = 16,
  parameter int W     = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Keep at least one bit so LIMIT = 0 still elaborates.
  localparam int CW = (W < 1) ? 1 : W;
  localparam logic [CW-1:0] START = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] remaining;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      remaining <= START;
    end else if (enable && (remaining != '0)) begin
      remaining <= remaining - CW'(1);
    end
  end

  assign expired = (LIMIT > 0) && (remaining == '0);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control unit. Steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB using req/ack handshakes with variable-latency
// instruction and data memories, traps on illegal classes, misaligned
// accesses and memory timeouts, and keeps cycle / retired-instruction counts.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   imem_req / imem_ack        instruction fetch handshake
//   dec_en / dec_done          decoder handshake
//   dec_class, dec_regwrite    decoded class and rd-write flag (held by decoder
//                              from dec_done through WB)
//   misaligned                 load/store address misaligned
//   dmem_req / dmem_we / dmem_ack  data memory handshake
//   rf_we, pc_we               register file / PC update strobes
//   busy, halted, trap         run status
//   trap_cause                 0 none, 1 illegal, 2 misaligned, 3 timeout
//   state_dbg                  current state encoding
//   cycle_cnt, instret_cnt     busy cycles and retired instructions (wrapping)
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dec_en,
  input  logic             dec_done,
  input  dec_class_t       dec_class,
  input  logic             dec_regwrite,
  input  logic             misaligned,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             busy,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t           state;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  logic to_clear;
  logic to_enable;
  logic to_expired;

  // One watchdog serves both memories: it is reloaded in every state other
  // than FETCH/MEM, so it starts fresh on entry to either.
  assign to_clear  = !((state == ST_FETCH) || (state == ST_MEM));
  assign to_enable = ((state == ST_FETCH) && !imem_ack) ||
                     ((state == ST_MEM)   && !dmem_ack);

  mc_timeout #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TO_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  // NOTE: all state updates are non-blocking so every branch below sees the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      cause_q   <= CAUSE_NONE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (busy) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end

      case (state)
        ST_FETCH: begin
          // An ack on the expiring cycle takes priority over the trap.
          if (imem_ack) begin
            state <= ST_DECODE;
          end else if (to_expired) begin
            state   <= ST_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end
        end

        ST_DECODE: begin
          if (dec_done) begin
            case (dec_class)
              CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP: begin
                state <= ST_EXECUTE;
              end
              CL_HALT: begin
                // HALT retires here; it never reaches WB, so no pc_we.
                state     <= ST_HALT;
                instret_q <= instret_q + CNT_W'(1);
              end
              default: begin
                // ILLEGAL and the unused encoding both trap.
                state   <= ST_TRAP;
                cause_q <= CAUSE_ILLEGAL;
              end
            endcase
          end
        end

        ST_EXECUTE: begin
          if (is_mem_class(dec_class)) begin
            if (misaligned) begin
              state   <= ST_TRAP;
              cause_q <= CAUSE_MISALIGNED;
            end else begin
              state <= ST_MEM;
            end
          end else begin
            state <= ST_WB;
          end
        end

        ST_MEM: begin
          if (dmem_ack) begin
            state <= ST_WB;
          end else if (to_expired) begin
            state   <= ST_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end
        end

        ST_WB: begin
          state     <= ST_FETCH;
          instret_q <= instret_q + CNT_W'(1);
        end

        default: begin
          // HALT and TRAP are terminal until reset.
        end
      endcase
    end
  end

  // Moore strobes decoded from the state register; rf_we also qualifies on
  // the decoder's latched class and regwrite flag.
  assign imem_req    = (state == ST_FETCH);
  assign dec_en      = (state == ST_DECODE);
  assign dmem_req    = (state == ST_MEM);
  assign dmem_we     = (state == ST_MEM) && (dec_class == CL_STORE);
  assign pc_we       = (state == ST_WB);
  assign rf_we       = (state == ST_WB) && dec_regwrite && writes_rd(dec_class);
  assign halted      = (state == ST_HALT);
  assign trap        = (state == ST_TRAP);
  assign busy        = !((state == ST_HALT) || (state == ST_TRAP));
  assign trap_cause  = cause_q;
  assign state_dbg   = state;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer. Two instances: dut_a with default parameters and
// dut_b with CNT_W=4, MEM_TIMEOUT=4. Instruction descriptors (class, wait
// cycles at fetch/decode/memory) are expanded into a per-cycle list of
// inputs and expected outputs; one process drives the list, one compares.
module tb_mc_sequencer;
  import mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        imem_req, dec_en, dmem_req, dmem_we, rf_we, pc_we;
    logic        busy, halted, trap;
    logic [1:0]  cause;
    logic [31:0] cyc, ret;
  } out_t;

  typedef struct packed {
    logic [15:0] idx;
    logic        sel, chk, reset, imem_ack, dec_done, dmem_ack, regw, mis;
    dec_class_t  cls;
    out_t        want;
  } vec_t;

  vec_t cur;
  logic cur_valid = 1'b0;
  vec_t vq[$];

  int nvec = 0;
  int nbad = 0;

  // Model state for the vector generator.
  int          m_cyc, m_ret, g_T;
  logic [1:0]  m_cause;
  logic [31:0] g_mask;
  logic        g_sel, g_regw, g_mis;
  dec_class_t  g_cls;

  // Shared DUT inputs; the idle instance is held in reset.
  logic       rst_a, rst_b, imem_ack, dec_done, dec_regwrite, misaligned, dmem_ack;
  dec_class_t dec_class;
  assign rst_a        = cur.sel ? 1'b1 : cur.reset;
  assign rst_b        = cur.sel ? cur.reset : 1'b1;
  assign imem_ack     = cur.imem_ack;
  assign dec_done     = cur.dec_done;
  assign dmem_ack     = cur.dmem_ack;
  assign dec_regwrite = cur.regw;
  assign misaligned   = cur.mis;
  assign dec_class    = cur.cls;

  logic        imem_req_a, dec_en_a, dmem_req_a, dmem_we_a, rf_we_a, pc_we_a;
  logic        busy_a, halted_a, trap_a;
  logic [1:0]  cause_a;
  logic [2:0]  st_a;
  logic [31:0] cyc_a, ret_a;

  logic        imem_req_b, dec_en_b, dmem_req_b, dmem_we_b, rf_we_b, pc_we_b;
  logic        busy_b, halted_b, trap_b;
  logic [1:0]  cause_b;
  logic [2:0]  st_b;
  logic [3:0]  cyc_b, ret_b;

  mc_sequencer dut_a (
    .clk (clk), .reset (rst_a),
    .imem_req (imem_req_a), .imem_ack (imem_ack),
    .dec_en (dec_en_a), .dec_done (dec_done),
    .dec_class (dec_class), .dec_regwrite (dec_regwrite), .misaligned (misaligned),
    .dmem_req (dmem_req_a), .dmem_we (dmem_we_a), .dmem_ack (dmem_ack),
    .rf_we (rf_we_a), .pc_we (pc_we_a),
    .busy (busy_a), .halted (halted_a), .trap (trap_a), .trap_cause (cause_a),
    .state_dbg (st_a), .cycle_cnt (cyc_a), .instret_cnt (ret_a)
  );

  mc_sequencer #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
    .clk (clk), .reset (rst_b),
    .imem_req (imem_req_b), .imem_ack (imem_ack),
    .dec_en (dec_en_b), .dec_done (dec_done),
    .dec_class (dec_class), .dec_regwrite (dec_regwrite), .misaligned (misaligned),
    .dmem_req (dmem_req_b), .dmem_we (dmem_we_b), .dmem_ack (dmem_ack),
    .rf_we (rf_we_b), .pc_we (pc_we_b),
    .busy (busy_b), .halted (halted_b), .trap (trap_b), .trap_cause (cause_b),
    .state_dbg (st_b), .cycle_cnt (cyc_b), .instret_cnt (ret_b)
  );

  out_t out_a, out_b;
  assign out_a = {st_a, imem_req_a, dec_en_a, dmem_req_a, dmem_we_a, rf_we_a, pc_we_a,
                  busy_a, halted_a, trap_a, cause_a, cyc_a, ret_a};
  assign out_b = {st_b, imem_req_b, dec_en_b, dmem_req_b, dmem_we_b, rf_we_b, pc_we_b,
                  busy_b, halted_b, trap_b, cause_b, 28'd0, cyc_b, 28'd0, ret_b};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    nvec++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %h, required %h", name, act, want);
    end
  endtask

  // One cycle in state st with the given acks; expected outputs follow from
  // the state, the current instruction, and the running counts.
  task automatic emit(input state_t st, input logic ai, input logic dd, input logic ad);
    vec_t v;
    v          = '0;
    v.idx      = 16'(vq.size());
    v.sel      = g_sel;
    v.chk      = 1'b1;
    v.imem_ack = ai;
    v.dec_done = dd;
    v.dmem_ack = ad;
    v.regw     = g_regw;
    v.mis      = g_mis;
    v.cls      = g_cls;
    v.want.st       = st;
    v.want.imem_req = (st == ST_FETCH);
    v.want.dec_en   = (st == ST_DECODE);
    v.want.dmem_req = (st == ST_MEM);
    v.want.dmem_we  = (st == ST_MEM) && (g_cls == CL_STORE);
    v.want.pc_we    = (st == ST_WB);
    v.want.rf_we    = (st == ST_WB) && g_regw && (g_cls inside {CL_ALU, CL_JUMP, CL_LOAD});
    v.want.halted   = (st == ST_HALT);
    v.want.trap     = (st == ST_TRAP);
    v.want.busy     = !(st inside {ST_HALT, ST_TRAP});
    v.want.cause    = m_cause;
    v.want.cyc      = 32'(m_cyc) & g_mask;
    v.want.ret      = 32'(m_ret) & g_mask;
    vq.push_back(v);
    if (v.want.busy) m_cyc++;
  endtask

  // Terminal states must ignore every handshake input.
  task automatic emit_hold(input state_t st);
    repeat (3) emit(st, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic gen_reset(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v       = '0;
      v.idx   = 16'(vq.size());
      v.sel   = g_sel;
      v.reset = 1'b1;
      vq.push_back(v);
    end
    m_cyc = 0; m_ret = 0; m_cause = CAUSE_NONE;
  endtask

  // f_wait/d_wait/m_wait: cycles of waiting before the ack/done arrives.
  task automatic gen_instr(input dec_class_t cls, input logic regw, input logic mis,
                           input int f_wait, input int d_wait, input int m_wait);
    g_cls = cls; g_regw = regw; g_mis = mis;
    if (g_T > 0 && f_wait >= g_T) begin
      repeat (g_T) emit(ST_FETCH, 1'b0, 1'b0, 1'b0);
      m_cause = CAUSE_TIMEOUT;
      emit_hold(ST_TRAP);
      return;
    end
    for (int i = 0; i <= f_wait; i++) emit(ST_FETCH, i == f_wait, 1'b0, 1'b0);
    for (int i = 0; i <= d_wait; i++) emit(ST_DECODE, 1'b0, i == d_wait, 1'b0);
    if (cls == CL_HALT) begin
      m_ret++;
      emit_hold(ST_HALT);
      return;
    end
    if (cls == CL_ILLEGAL) begin
      m_cause = CAUSE_ILLEGAL;
      emit_hold(ST_TRAP);
      return;
    end
    emit(ST_EXECUTE, 1'b0, 1'b0, 1'b0);
    if (cls inside {CL_LOAD, CL_STORE}) begin
      if (mis) begin
        m_cause = CAUSE_MISALIGNED;
        emit_hold(ST_TRAP);
        return;
      end
      if (g_T > 0 && m_wait >= g_T) begin
        repeat (g_T) emit(ST_MEM, 1'b0, 1'b0, 1'b0);
        m_cause = CAUSE_TIMEOUT;
        emit_hold(ST_TRAP);
        return;
      end
      for (int i = 0; i <= m_wait; i++) emit(ST_MEM, 1'b0, 1'b0, i == m_wait);
    end
    emit(ST_WB, 1'b0, 1'b0, 1'b0);
    m_ret++;
  endtask

  // Compare process: one check per driven, non-reset cycle.
  always @(negedge clk) begin
    if (cur_valid && cur.chk)
      check($sformatf("vec%0d_dut%s", cur.idx, cur.sel ? "b" : "a"),
            cur.sel ? out_b : out_a, cur.want);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, last;
    cur = '0; cur.reset = 1'b1;
    g_sel = 1'b0; g_T = 16; g_mask = 32'hFFFF_FFFF;
    g_cls = CL_ALU; g_regw = 1'b0; g_mis = 1'b0;

    // ---------------- dut_a: CNT_W=32, MEM_TIMEOUT=16 ----------------
    gen_reset(3);
    base = vq.size();
    gen_instr(CL_ALU, 1'b1, 1'b0, 0, 0, 0);
    check("alu_length", vq.size() - base, 4);
    check("alu_imem_req_c0", vq[base].want.imem_req, 1'b1);
    check("alu_wb_rf_pc", {vq[base+3].want.rf_we, vq[base+3].want.pc_we}, 2'b11);

    base = vq.size();
    gen_instr(CL_LOAD, 1'b1, 1'b0, 0, 0, 5);
    check("alu_counts_after", {vq[base].want.ret, vq[base].want.cyc}, {32'd1, 32'd4});
    n = 0;
    for (int k = base; k < vq.size(); k++) if (vq[k].want.dmem_req) n++;
    check("load_req_cycles", n, 6);
    last = vq.size() - 1;
    check("load_wb", {vq[last].want.st, vq[last].want.rf_we, vq[last-1].want.dmem_we},
          {ST_WB, 1'b1, 1'b0});

    gen_instr(CL_STORE, 1'b1, 1'b0, 0, 0, 0);
    last = vq.size() - 1;
    check("store_wb", {vq[last-1].want.dmem_we, vq[last].want.rf_we, vq[last].want.pc_we},
          3'b101);
    gen_instr(CL_JUMP,   1'b0, 1'b0, 2, 1, 0);
    gen_instr(CL_BRANCH, 1'b1, 1'b0, 0, 0, 0);
    gen_instr(CL_ALU,    1'b0, 1'b0, 1, 2, 0);
    gen_instr(CL_STORE,  1'b1, 1'b1, 0, 0, 0);
    last = vq.size() - 1;
    check("misaligned_trap", {vq[last].want.trap, vq[last].want.cause, vq[last].want.busy},
          {1'b1, CAUSE_MISALIGNED, 1'b0});

    gen_reset(2);
    gen_instr(CL_ILLEGAL, 1'b0, 1'b0, 0, 0, 0);
    last = vq.size() - 1;
    check("illegal_frozen", {vq[last].want.cause, vq[last].want.cyc, vq[last].want.ret},
          {CAUSE_ILLEGAL, 32'd2, 32'd0});

    gen_reset(2);
    gen_instr(CL_ALU, 1'b1, 1'b0, 0, 0, 0);
    gen_instr(CL_HALT, 1'b0, 1'b0, 0, 0, 0);
    last = vq.size() - 1;
    check("halt_counts", {vq[last].want.halted, vq[last].want.ret, vq[last].want.cyc},
          {1'b1, 32'd2, 32'd6});

    // Reset lands while a load is waiting in MEM.
    gen_reset(2);
    g_cls = CL_LOAD; g_regw = 1'b1; g_mis = 1'b0;
    emit(ST_FETCH, 1'b1, 1'b0, 1'b0);
    emit(ST_DECODE, 1'b0, 1'b1, 1'b0);
    emit(ST_EXECUTE, 1'b0, 1'b0, 1'b0);
    emit(ST_MEM, 1'b0, 1'b0, 1'b0);
    emit(ST_MEM, 1'b0, 1'b0, 1'b0);
    gen_reset(1);
    base = vq.size();
    gen_instr(CL_ALU, 1'b1, 1'b0, 0, 0, 0);
    check("post_reset_fetch", {vq[base].want.dmem_req, vq[base].want.cyc, vq[base].want.ret},
          {1'b0, 32'd0, 32'd0});

    // ---------------- dut_b: CNT_W=4, MEM_TIMEOUT=4 ----------------
    g_sel = 1'b1; g_T = 4; g_mask = 32'h0000_000F;
    gen_reset(2);
    base = vq.size();
    gen_instr(CL_ALU, 1'b1, 1'b0, 50, 0, 0);
    n = 0;
    for (int k = base; k < vq.size(); k++) if (vq[k].want.imem_req) n++;
    check("fetch_timeout_req_cycles", n, 4);
    check("fetch_timeout_cause", vq[vq.size()-1].want.cause, CAUSE_TIMEOUT);

    gen_reset(2);
    base = vq.size();
    gen_instr(CL_ALU, 1'b1, 1'b0, 3, 0, 0);
    check("ack_on_last_cycle", vq[base+4].want.st, ST_DECODE);
    gen_instr(CL_LOAD, 1'b1, 1'b0, 0, 0, 3);
    gen_instr(CL_LOAD, 1'b1, 1'b0, 0, 0, 4);
    check("mem_timeout_cause", vq[vq.size()-1].want.cause, CAUSE_TIMEOUT);

    gen_reset(2);
    repeat (16) gen_instr(CL_ALU, 1'b1, 1'b0, 0, 0, 0);
    base = vq.size();
    gen_instr(CL_ALU, 1'b1, 1'b0, 0, 0, 0);
    check("wrap_before", {vq[base-1].want.cyc, vq[base-1].want.ret}, {32'd15, 32'd15});
    check("wrap_after",  {vq[base].want.cyc,   vq[base].want.ret},   {32'd0,  32'd0});

    // ---------------- drive the vector list ----------------
    foreach (vq[k]) begin
      @(posedge clk);
      #1;
      cur       = vq[k];
      cur_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    cur_valid = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
